count_monitor: RTL and testbench

- Passive observer for the up/down counter. Samples the counter's count output and its direction and reset controls every cycle.
- Predicts the next count, flags mismatches, reports wrap-around events and accumulates an error count.
- Sits alongside the counter in the subsystem and in the bench as the reading end of the counter interface. It never drives the counter.

---
 rtl/count_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_count_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
//
// Passive observer for an up/down counter. Every cycle it samples the counter's
// output, direction and reset and predicts the next count. It flags mismatches,
// reports wrap-around events and keeps a saturating error count. It never
// drives the counter.
//
// Optional feature (macro COUNT_MONITOR_FIRST_ERR_EN):
//   When defined, the expected and observed values of the first mismatch after
//   reset or clr_err are captured on first_exp / first_obs, and first_vld is
//   set. Later mismatches do not overwrite them. When undefined, these ports
//   and registers do not exist.
//
// Parameters:
//   WIDTH      width of the observed count
//   ERR_W      width of the saturating error counter
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset of the monitor
//   enable     1 = monitor active, 0 = forced to IDLE
//   cnt_rstn   counter reset as seen by the counter (0 = counter held at 0)
//   up_dwn     counter direction as sampled by the counter (1 = up)
//   count_in   counter output
//   clr_err    synchronous clear of err_cnt and the first-error capture
//   locked     in TRACK with the most recent compare successful
//   mismatch   one-cycle pulse, observed count differed from the prediction
//   wrap_up    one-cycle pulse, max -> 0 observed while counting up
//   wrap_dn    one-cycle pulse, 0 -> max observed while counting down
//   expected   current prediction for count_in
//   err_cnt    saturating mismatch count
//   first_exp  (optional) prediction at the first mismatch
//   first_obs  (optional) observed value at the first mismatch
//   first_vld  (optional) first_exp / first_obs hold a capture
//
// States:
//   state | meaning
//   IDLE  | monitor disabled, outputs other than err_cnt held at 0
//   SYNC  | capturing count/direction, waiting for the counter to leave reset
//   TRACK | predicting and comparing every cycle
// -----------------------------------------------------------------------------
module count_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             cnt_rstn,
    input  logic             up_dwn,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic [WIDTH-1:0] expected,
    output logic [ERR_W-1:0] err_cnt
`ifdef COUNT_MONITOR_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic             first_vld
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev_cnt;
    logic [WIDTH-1:0] prev_cnt_nxt;
    logic             prev_dir;
    logic             prev_dir_nxt;
    logic             locked_nxt;
    logic             mismatch_nxt;
    logic             wrap_up_nxt;
    logic             wrap_dn_nxt;
    logic [WIDTH-1:0] expected_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic             err_hit;

    // Prediction for the value now on count_in, built from last cycle's sample.
    logic [WIDTH-1:0] exp_now;
    // Prediction for next cycle, built from this cycle's sample.
    logic [WIDTH-1:0] pred_next;
    logic [ERR_W-1:0] err_inc;

    assign exp_now   = prev_dir ? (prev_cnt + CNT_ONE) : (prev_cnt - CNT_ONE);
    assign pred_next = up_dwn   ? (count_in + CNT_ONE) : (count_in - CNT_ONE);
    assign err_inc   = (err_cnt == ERR_MAX) ? err_cnt : (err_cnt + ERR_ONE);

    always_comb begin
        state_nxt    = state;
        prev_cnt_nxt = prev_cnt;
        prev_dir_nxt = prev_dir;
        locked_nxt   = 1'b0;
        mismatch_nxt = 1'b0;
        wrap_up_nxt  = 1'b0;
        wrap_dn_nxt  = 1'b0;
        expected_nxt = expected;
        err_cnt_nxt  = err_cnt;
        err_hit      = 1'b0;

        if (!enable) begin
            state_nxt    = IDLE;
            expected_nxt = CNT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = SYNC;
                    expected_nxt = CNT_ZERO;
                end
                SYNC: begin
                    prev_cnt_nxt = count_in;
                    prev_dir_nxt = up_dwn;
                    expected_nxt = CNT_ZERO;
                    state_nxt    = cnt_rstn ? TRACK : SYNC;
                end
                TRACK: begin
                    prev_cnt_nxt = count_in;
                    prev_dir_nxt = up_dwn;
                    expected_nxt = pred_next;
                    if (!cnt_rstn) begin
                        // A counter reset mid-count is legitimate: resync, no compare.
                        state_nxt = SYNC;
                    end else if (count_in != exp_now) begin
                        // Stay in TRACK; prev_cnt follows the observed value so
                        // tracking resumes from it on the next cycle.
                        mismatch_nxt = 1'b1;
                        err_cnt_nxt  = err_inc;
                        err_hit      = 1'b1;
                    end else begin
                        locked_nxt  = 1'b1;
                        wrap_up_nxt = prev_dir  && (prev_cnt == CNT_MAX)  && (count_in == CNT_ZERO);
                        wrap_dn_nxt = !prev_dir && (prev_cnt == CNT_ZERO) && (count_in == CNT_MAX);
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    expected_nxt = CNT_ZERO;
                end
            endcase
        end

        // Clear takes priority over a same-cycle increment; the pulse still fires.
        if (clr_err) begin
            err_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            prev_cnt <= '0;
            prev_dir <= 1'b0;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            expected <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            prev_cnt <= prev_cnt_nxt;
            prev_dir <= prev_dir_nxt;
            locked   <= locked_nxt;
            mismatch <= mismatch_nxt;
            wrap_up  <= wrap_up_nxt;
            wrap_dn  <= wrap_dn_nxt;
            expected <= expected_nxt;
            err_cnt  <= err_cnt_nxt;
        end
    end

`ifdef COUNT_MONITOR_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_exp <= '0;
            first_obs <= '0;
            first_vld <= 1'b0;
        end else if (clr_err) begin
            first_exp <= '0;
            first_obs <= '0;
            first_vld <= 1'b0;
        end else if (err_hit && !first_vld) begin
            first_exp <= exp_now;
            first_obs <= count_in;
            first_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic       cnt_rstn;
    logic       up_dwn;
    logic [3:0] count_in;
    logic       clr_err;

    logic       locked, mismatch, wrap_up, wrap_dn;
    logic [3:0] expected;
    logic [7:0] err_cnt;

    logic       locked2, mismatch2, wrap_up2, wrap_dn2;
    logic [3:0] expected2;
    logic [1:0] err_cnt2;

`ifdef COUNT_MONITOR_FIRST_ERR_EN
    logic [3:0] first_exp, first_obs, first_exp2, first_obs2;
    logic       first_vld, first_vld2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_monitor #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .cnt_rstn(cnt_rstn),
        .up_dwn(up_dwn), .count_in(count_in), .clr_err(clr_err),
        .locked(locked), .mismatch(mismatch), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
        .expected(expected), .err_cnt(err_cnt)
`ifdef COUNT_MONITOR_FIRST_ERR_EN
        , .first_exp(first_exp), .first_obs(first_obs), .first_vld(first_vld)
`endif
    );

    count_monitor #(.WIDTH(4), .ERR_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .enable(enable), .cnt_rstn(cnt_rstn),
        .up_dwn(up_dwn), .count_in(count_in), .clr_err(clr_err),
        .locked(locked2), .mismatch(mismatch2), .wrap_up(wrap_up2), .wrap_dn(wrap_dn2),
        .expected(expected2), .err_cnt(err_cnt2)
`ifdef COUNT_MONITOR_FIRST_ERR_EN
        , .first_exp(first_exp2), .first_obs(first_obs2), .first_vld(first_vld2)
`endif
    );

    // Present one cycle of counter activity, then sample just after the edge.
    task automatic step(input logic [3:0] c, input logic dir, input logic crst,
                        input logic clr, input logic en);
        @(negedge clk);
        count_in = c;
        up_dwn   = dir;
        cnt_rstn = crst;
        clr_err  = clr;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; cnt_rstn = 1'b0; up_dwn = 1'b0;
        count_in = 4'h0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0b want 0", mismatch); end
        checks++; if ({wrap_up, wrap_dn} !== 2'b00) begin errors++; $display("FAIL reset_wrap: got %b want 00", {wrap_up, wrap_dn}); end
        checks++; if (expected !== 4'h0) begin errors++; $display("FAIL reset_expected: got %0h want 0", expected); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_up_count();
        step(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);   // IDLE -> SYNC
        step(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);   // SYNC held by counter reset
        for (int k = 0; k < 20; k++) begin
            step(4'(k), 1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL up_mismatch k=%0d: got %0b want 0", k, mismatch); end
            checks++; if (wrap_up !== (k == 16)) begin errors++; $display("FAIL up_wrap_up k=%0d: got %0b want %0b", k, wrap_up, (k == 16)); end
            if (k >= 1) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL up_locked k=%0d: got %0b want 1", k, locked); end
                checks++; if (expected !== 4'(k + 1)) begin errors++; $display("FAIL up_expected k=%0d: got %0h want %0h", k, expected, 4'(k + 1)); end
            end else begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL up_locked_sync: got %0b want 0", locked); end
            end
        end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL up_err_cnt: got %0h want 0", err_cnt); end
    endtask

    task automatic test_down_wrap();
        logic [3:0] seq [7];
        seq = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
        for (int i = 0; i < 7; i++) begin
            step(seq[i], 1'b0, 1'b1, 1'b0, 1'b1);
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL dn_mismatch v=%0h: got %0b want 0", seq[i], mismatch); end
            checks++; if (wrap_dn !== (seq[i] == 4'hF)) begin errors++; $display("FAIL dn_wrap_dn v=%0h: got %0b want %0b", seq[i], wrap_dn, (seq[i] == 4'hF)); end
            checks++; if (expected !== 4'(seq[i] - 4'h1)) begin errors++; $display("FAIL dn_expected v=%0h: got %0h want %0h", seq[i], expected, 4'(seq[i] - 4'h1)); end
        end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL dn_err_cnt: got %0h want 0", err_cnt); end
    endtask

    task automatic test_dir_flip();
        for (int i = 13; i <= 22; i++) begin
            step(4'(i), 1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL flip_up_mismatch v=%0h: got %0b want 0", 4'(i), mismatch); end
        end
        for (int i = 7; i >= 1; i--) begin
            step(4'(i), 1'b0, 1'b1, 1'b0, 1'b1);
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL flip_dn_mismatch v=%0h: got %0b want 0", 4'(i), mismatch); end
            checks++; if (expected !== 4'(i - 1)) begin errors++; $display("FAIL flip_expected v=%0h: got %0h want %0h", 4'(i), expected, 4'(i - 1)); end
        end
        step(4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL flip_zero_mismatch: got %0b want 0", mismatch); end
        checks++; if (expected !== 4'h1) begin errors++; $display("FAIL flip_zero_expected: got %0h want 1", expected); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL flip_locked: got %0b want 1", locked); end
    endtask

    task automatic test_fault();
        for (int i = 1; i <= 5; i++) step(4'(i), 1'b1, 1'b1, 1'b0, 1'b1);
        step(4'h9, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_mismatch: got %0b want 1", mismatch); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL fault_err_cnt: got %0h want 1", err_cnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fault_locked_drop: got %0b want 0", locked); end
        checks++; if (expected !== 4'hA) begin errors++; $display("FAIL fault_expected: got %0h want a", expected); end
`ifdef COUNT_MONITOR_FIRST_ERR_EN
        checks++; if ({first_vld, first_exp, first_obs} !== {1'b1, 4'h6, 4'h9}) begin errors++; $display("FAIL fault_first: got vld=%0b exp=%0h obs=%0h want 1/6/9", first_vld, first_exp, first_obs); end
`endif
        step(4'hA, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL fault_pulse_end: got %0b want 0", mismatch); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL fault_relock: got %0b want 1", locked); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL fault_err_hold: got %0h want 1", err_cnt); end
    endtask

    task automatic test_cnt_reset();
        step(4'hB, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL crst_pre_locked: got %0b want 1", locked); end
        step(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);   // counter snaps to 0; would mismatch if compared
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL crst_mismatch: got %0b want 0", mismatch); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL crst_locked: got %0b want 0", locked); end
        step(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (expected !== 4'h0) begin errors++; $display("FAIL crst_sync_expected: got %0h want 0", expected); end
        step(4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL crst_sync_exit_locked: got %0b want 0", locked); end
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL crst_relock: got %0b want 1", locked); end
        checks++; if (expected !== 4'h2) begin errors++; $display("FAIL crst_expected: got %0h want 2", expected); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL crst_err_cnt: got %0h want 1", err_cnt); end
    endtask

    task automatic test_saturation();
        step(4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL sat_clear8: got %0h want 0", err_cnt); end
        checks++; if (err_cnt2 !== 2'h0) begin errors++; $display("FAIL sat_clear2: got %0h want 0", err_cnt2); end
        for (int i = 1; i <= 5; i++) begin
            step(4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (mismatch2 !== 1'b1) begin errors++; $display("FAIL sat_mismatch i=%0d: got %0b want 1", i, mismatch2); end
            checks++; if (err_cnt2 !== 2'((i > 3) ? 3 : i)) begin errors++; $display("FAIL sat_err_cnt2 i=%0d: got %0h want %0h", i, err_cnt2, 2'((i > 3) ? 3 : i)); end
            checks++; if (err_cnt !== 8'(i)) begin errors++; $display("FAIL sat_err_cnt8 i=%0d: got %0h want %0h", i, err_cnt, 8'(i)); end
        end
`ifdef COUNT_MONITOR_FIRST_ERR_EN
        checks++; if ({first_vld, first_exp, first_obs} !== {1'b1, 4'h3, 4'h5}) begin errors++; $display("FAIL sat_first: got vld=%0b exp=%0h obs=%0h want 1/3/5", first_vld, first_exp, first_obs); end
`endif
        step(4'h5, 1'b1, 1'b1, 1'b1, 1'b1);   // 6th mismatch together with clear
        checks++; if (mismatch2 !== 1'b1) begin errors++; $display("FAIL sat_clr_pulse: got %0b want 1", mismatch2); end
        checks++; if (err_cnt2 !== 2'h0) begin errors++; $display("FAIL sat_clr_wins2: got %0h want 0", err_cnt2); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL sat_clr_wins8: got %0h want 0", err_cnt); end
`ifdef COUNT_MONITOR_FIRST_ERR_EN
        checks++; if ({first_vld, first_exp, first_obs} !== 9'h0) begin errors++; $display("FAIL sat_first_clr: got vld=%0b exp=%0h obs=%0h want 0/0/0", first_vld, first_exp, first_obs); end
`endif
        step(4'h6, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL sat_resume_mismatch: got %0b want 0", mismatch); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_resume_locked: got %0b want 1", locked); end
    endtask

    task automatic test_enable_drop();
        step(4'h9, 1'b1, 1'b1, 1'b0, 1'b1);   // predicted 7
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL en_err_cnt: got %0h want 1", err_cnt); end
        step(4'h0, 1'b1, 1'b1, 1'b0, 1'b0);   // wrong value, but monitor disabled
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL en_mismatch: got %0b want 0", mismatch); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_locked: got %0b want 0", locked); end
        checks++; if (expected !== 4'h0) begin errors++; $display("FAIL en_expected: got %0h want 0", expected); end
        step(4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL en_err_retained: got %0h want 1", err_cnt); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL en_idle_mismatch: got %0b want 0", mismatch); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_dir_flip();
        test_fault();
        test_cnt_reset();
        test_saturation();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
